// File: rtl/opb_status_regbank.sv
// OPB slave register bank that captures per-channel user status words in live, snapshot or sticky-OR views.
// Each channel also keeps a capture count and a new-data flag.
module opb_status_regbank #(
    parameter logic [31:0] C_BASEADDR    = 32'h01080D00,
    parameter logic [31:0] C_HIGHADDR    = 32'h01080DFF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_CH      = 4,
    parameter int          C_USER_DWIDTH = 32
) (
    input  logic                                OPB_Clk,
    input  logic                                OPB_Rst,
    input  logic [0:31]                         OPB_ABus,
    input  logic [0:3]                          OPB_BE,
    input  logic [0:31]                         OPB_DBus,
    input  logic                                OPB_RNW,
    input  logic                                OPB_select,
    input  logic                                OPB_seqAddr,
    output logic [0:31]                         Sl_DBus,
    output logic                                Sl_xferAck,
    output logic                                Sl_errAck,
    output logic                                Sl_retry,
    output logic                                Sl_toutSup,
    input  logic [C_NUM_CH*C_USER_DWIDTH-1:0]   user_data_in,
    input  logic [C_NUM_CH-1:0]                 user_valid
);

    localparam int W = C_USER_DWIDTH;
    localparam int N = C_NUM_CH;

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_HOLD} state_t;

    state_t                 state;
    logic                   armed;
    logic                   ack_q;
    logic [31:0]            dbus_q;
    logic [1:0]             mode;
    logic                   snap_req;
    logic [W-1:0]           live   [N];
    logic [W-1:0]           shadow [N];
    logic [15:0]            count  [N];
    logic [N-1:0]           newflag;

    logic [C_OPB_AWIDTH-1:0] off;
    logic [31:0]             wdata;
    logic [C_OPB_DWIDTH-1:0] rd_mux;
    logic [N-1:0]            data_rd;
    logic [5:0]              reg_sel;
    logic                    addr_hit;
    logic                    start;
    logic                    word_ok;
    logic                    wr_ctrl;
    logic                    use_shadow;
    logic                    unused_ok;

    function automatic logic [31:0] zext(input logic [W-1:0] v);
        logic [31:0] r;
        r        = '0;
        r[W-1:0] = v;
        return r;
    endfunction

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign Sl_xferAck = ack_q;
    assign Sl_DBus    = dbus_q;

    assign wdata      = OPB_DBus;
    assign off        = OPB_ABus - C_BASEADDR;
    assign addr_hit   = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    // armed blocks a select that was already high across a reset from being acked
    assign start      = (state == S_IDLE) && addr_hit && armed;
    assign word_ok    = (off[C_OPB_AWIDTH-1:8] == '0) && (off[1:0] == 2'b00);
    assign reg_sel    = off[7:2];
    assign wr_ctrl    = start && !OPB_RNW && (OPB_BE == 4'b1111) && word_ok && (reg_sel == 6'd0);
    assign use_shadow = (mode == 2'b01) || (mode == 2'b10);
    assign unused_ok  = &{1'b0, OPB_seqAddr, wdata[30:2]};

    // register decode: CTRL, NEWFLAGS, DATA block at word 16, COUNT block at word 32
    always_comb begin
        rd_mux  = '0;
        data_rd = '0;
        if (word_ok) begin
            if (reg_sel == 6'd0)
                rd_mux[1:0] = mode;
            else if (reg_sel == 6'd1)
                rd_mux[N-1:0] = newflag;
            for (int i = 0; i < N; i++) begin
                if (reg_sel == 6'(16 + i)) begin
                    rd_mux     = zext(use_shadow ? shadow[i] : live[i]);
                    data_rd[i] = start && OPB_RNW;
                end
                if (reg_sel == 6'(32 + i))
                    rd_mux[15:0] = count[i];
            end
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state    <= S_IDLE;
            armed    <= 1'b0;
            ack_q    <= 1'b0;
            dbus_q   <= '0;
            mode     <= 2'b00;
            snap_req <= 1'b0;
        end else begin
            if (!OPB_select)
                armed <= 1'b1;
            ack_q    <= start;
            dbus_q   <= (start && OPB_RNW) ? rd_mux : '0;
            snap_req <= wr_ctrl && wdata[31];
            if (wr_ctrl)
                mode <= wdata[1:0];
            case (state)
                S_IDLE:  if (start) state <= S_ACK;
                S_ACK:   state <= S_HOLD;
                S_HOLD:  if (!OPB_select) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // per-channel capture; a capture in the same cycle as a DATA read wins over the clear
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            for (int i = 0; i < N; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
                count[i]  <= '0;
            end
            newflag <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (user_valid[i]) begin
                    live[i]  <= user_data_in[i*W +: W];
                    count[i] <= count[i] + 16'd1;
                end
                newflag[i] <= user_valid[i] | (newflag[i] & ~data_rd[i]);
                if (snap_req && (mode == 2'b01))
                    shadow[i] <= live[i];
                else if (mode == 2'b10) begin
                    if (data_rd[i])
                        shadow[i] <= user_valid[i] ? user_data_in[i*W +: W] : '0;
                    else if (user_valid[i])
                        shadow[i] <= shadow[i] | user_data_in[i*W +: W];
                end
            end
        end
    end

endmodule
